// File: rtl/alu_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Instruction sequencer for the register-file/ALU datapath.
//                Accepts 16-bit instruction words on a valid/ready handshake,
//                decodes them into datapath controls, issues a single register
//                write per legal instruction, captures the ALU flags and the
//                written value, and pulses done (with err for illegal words).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int NUM_OPS = 10,
    parameter int IMM_W   = 7
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  rf_rdest,
    output logic [3:0]  rf_rsrc,
    output logic [4:0]  rf_opcode,
    output logic [15:0] rf_imm,
    output logic        rf_imm_s,
    output logic        rf_en,
    input  logic [4:0]  alu_flags,
    input  logic [15:0] rdest_out,
    output logic        done,
    output logic        err,
    output logic [15:0] result,
    output logic [4:0]  flags_q
);

    // Compare only updates flags; it never writes its destination register.
    localparam logic [3:0] c_OP_CMP = 4'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr;
    logic        r_err;
    logic [15:0] r_result;
    logic [4:0]  r_flags;

    // Field decode of the latched word; the live instr input never reaches rf_*.
    logic             w_imm_f;
    logic [3:0]       w_op;
    logic [3:0]       w_rdest;
    logic [3:0]       w_rsrc;
    logic [IMM_W-1:0] w_imm_raw;
    logic [15:0]      w_imm_sx;
    logic             w_bad;

    assign w_imm_f   = r_instr[15];
    assign w_op      = r_instr[14:11];
    assign w_rdest   = r_instr[10:7];
    assign w_rsrc    = r_instr[6:3];
    assign w_imm_raw = r_instr[IMM_W-1:0];
    assign w_imm_sx  = {{(16-IMM_W){w_imm_raw[IMM_W-1]}}, w_imm_raw};
    // Illegal: opcode out of range, or register form with nonzero reserved bits.
    assign w_bad     = ({28'd0, w_op} >= 32'(NUM_OPS)) ||
                       (!w_imm_f && (r_instr[2:0] != 3'd0));

    assign result  = r_result;
    assign flags_q = r_flags;

    // State register, instruction latch and completion captures.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state  <= S_IDLE;
            r_instr  <= 16'd0;
            r_err    <= 1'b0;
            r_result <= 16'd0;
            r_flags  <= 5'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && instr_valid) begin
                r_instr <= instr;
            end
            if (r_state == S_DECODE) begin
                r_err <= w_bad;
            end
            if (r_state == S_EXEC) begin
                r_flags <= alu_flags;
            end
            // rdest_out already reflects the write performed at the end of EXEC.
            if (r_state == S_DONE && !r_err) begin
                r_result <= rdest_out;
            end
        end
    end

    // Next-state logic and state-decoded datapath controls.
    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        rf_rdest    = 4'd0;
        rf_rsrc     = 4'd0;
        rf_opcode   = 5'd0;
        rf_imm      = 16'd0;
        rf_imm_s    = 1'b0;
        rf_en       = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        if (r_state != S_IDLE) begin
            rf_rdest  = w_rdest;
            rf_rsrc   = w_imm_f ? 4'd0 : w_rsrc;
            rf_opcode = {1'b0, w_op};
            rf_imm    = w_imm_f ? w_imm_sx : 16'd0;
            rf_imm_s  = w_imm_f;
        end

        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_bad ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                rf_en  = (w_op != c_OP_CMP);
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                err    = r_err;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
